// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
// Carries hazard sources in one direction and latch controls plus status in the other.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             ifid_uses_rt;
    logic             ex_branch_taken;
    logic             ex_jump;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic             mem_err;
    logic [1:0]       ctrl_state;

    modport master (
        output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               ex_branch_taken, ex_jump, mem_req, mem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               stall_cycles, flush_events, mem_err, ctrl_state
    );

    modport slave (
        input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt,
               ex_branch_taken, ex_jump, mem_req, mem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               stall_cycles, flush_events, mem_err, ctrl_state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch/jump squash, memory freeze,
// post-reset purge, memory-wait timeout and saturating performance counters.
module hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [INIT_W-1:0]  init_cnt_reg, init_cnt_next;
    logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]   stall_reg, flush_reg;
    logic               err_reg, err_next;
    logic               stall_inc, redirect_apply;

    logic mem_wait, redirect, load_use;

    assign mem_wait = hz.mem_req & ~hz.mem_ready;
    assign redirect = hz.ex_branch_taken | hz.ex_jump;
    assign load_use = hz.idex_memread && (hz.idex_rt != 5'd0) &&
                      ((hz.idex_rt == hz.ifid_rs) ||
                       (hz.ifid_uses_rt && (hz.idex_rt == hz.ifid_rt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT;
            init_cnt_reg <= '0;
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
            stall_reg    <= '0;
            flush_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
            if (stall_inc && (stall_reg != {CNT_W{1'b1}}))
                stall_reg <= stall_reg + 1'b1;
            if (redirect_apply && (flush_reg != {CNT_W{1'b1}}))
                flush_reg <= flush_reg + 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_cnt_next  = init_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;
        err_next       = err_reg;
        stall_inc      = 1'b0;
        redirect_apply = 1'b0;
        // INIT and ERROR purge every latch and hold the front end.
        hz.pc_write    = 1'b0;
        hz.ifid_write  = 1'b0;
        hz.idex_write  = 1'b0;
        hz.exmem_write = 1'b0;
        hz.ifid_flush  = 1'b1;
        hz.idex_flush  = 1'b1;
        hz.exmem_flush = 1'b1;
        hz.memwb_flush = 1'b1;

        case (state_reg)
            ST_INIT: begin
                if (init_cnt_reg == INIT_W'(INIT_CYCLES - 1)) begin
                    state_next    = ST_RUN;
                    init_cnt_next = '0;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                hz.ifid_flush  = 1'b0;
                hz.idex_flush  = 1'b0;
                hz.exmem_flush = 1'b0;
                hz.memwb_flush = 1'b0;
                if (mem_wait) begin
                    // Freeze everything up to EX/MEM; MEM/WB takes a bubble.
                    hz.memwb_flush = 1'b1;
                    stall_inc      = 1'b1;
                    if (state_reg == ST_RUN) begin
                        state_next    = ST_MEM_WAIT;
                        wait_cnt_next = WAIT_W'(1);
                    end else if (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) begin
                        state_next = ST_ERROR;
                        err_next   = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 1'b1;
                    end
                end else begin
                    state_next     = ST_RUN;
                    wait_cnt_next  = '0;
                    hz.pc_write    = 1'b1;
                    hz.ifid_write  = 1'b1;
                    hz.idex_write  = 1'b1;
                    hz.exmem_write = 1'b1;
                    if (redirect) begin
                        hz.ifid_flush  = 1'b1;
                        hz.idex_flush  = 1'b1;
                        redirect_apply = 1'b1;
                    end else if (load_use) begin
                        hz.pc_write   = 1'b0;
                        hz.ifid_write = 1'b0;
                        hz.idex_flush = 1'b1;
                        stall_inc     = 1'b1;
                    end
                end
            end
            default: ; // ST_ERROR: held until reset
        endcase
    end

    assign hz.stall_cycles = stall_reg;
    assign hz.flush_events = flush_reg;
    assign hz.mem_err      = err_reg;
    assign hz.ctrl_state   = state_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance with 2-bit counters exercises saturation.
module tb_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    hazard_ctrl_if #(.CNT_W(16)) hif ();
    hazard_ctrl_if #(.CNT_W(2))  hif_s ();

    hazard_ctrl #(.INIT_CYCLES(4), .TIMEOUT(64), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    hazard_ctrl #(.INIT_CYCLES(4), .TIMEOUT(64), .CNT_W(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif_s)
    );

    // {pc, ifid, idex, exmem writes, ifid, idex, exmem, memwb flushes}
    logic [7:0] ctl;
    assign ctl = {hif.pc_write, hif.ifid_write, hif.idex_write, hif.exmem_write,
                  hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle();
        hif.idex_memread    = 1'b0;
        hif.idex_rt         = 5'd0;
        hif.ifid_rs         = 5'd0;
        hif.ifid_rt         = 5'd0;
        hif.ifid_uses_rt    = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.ex_jump         = 1'b0;
        hif.mem_req         = 1'b0;
        hif.mem_ready       = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic init_sequence(input string tag);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_init_state"}, 32'(hif.ctrl_state), 32'd0);
            check({tag, "_init_ctl"}, 32'(ctl), 32'h0F);
            next_cycle();
        end
        @(negedge clk);
        check({tag, "_run_state"}, 32'(hif.ctrl_state), 32'd1);
        check({tag, "_run_ctl"}, 32'(ctl), 32'hF0);
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        hif_s.idex_memread    = 1'b0;
        hif_s.idex_rt         = 5'd0;
        hif_s.ifid_rs         = 5'd0;
        hif_s.ifid_rt         = 5'd0;
        hif_s.ifid_uses_rt    = 1'b0;
        hif_s.ex_branch_taken = 1'b0;
        hif_s.ex_jump         = 1'b1;
        hif_s.mem_req         = 1'b0;
        hif_s.mem_ready       = 1'b0;

        repeat (2) next_cycle();
        @(negedge clk);
        check("rst_state", 32'(hif.ctrl_state), 32'd0);
        check("rst_ctl", 32'(ctl), 32'h0F);
        check("rst_stall", 32'(hif.stall_cycles), 32'd0);
        check("rst_flush", 32'(hif.flush_events), 32'd0);
        check("rst_err", 32'(hif.mem_err), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        init_sequence("boot");

        // load-use on rs
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd5; hif.ifid_rs = 5'd5;
        @(negedge clk);
        check("lu_rs_ctl", 32'(ctl), 32'h34);
        next_cycle();
        idle();
        @(negedge clk);
        check("lu_rs_clear_ctl", 32'(ctl), 32'hF0);
        check("lu_rs_stall", 32'(hif.stall_cycles), 32'd1);
        next_cycle();

        // $0 never stalls
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd0; hif.ifid_rs = 5'd0;
        @(negedge clk);
        check("lu_r0_ctl", 32'(ctl), 32'hF0);
        next_cycle();
        check("lu_r0_stall", 32'(hif.stall_cycles), 32'd1);

        // load-use on rt, only when rt is read
        hif.idex_rt = 5'd7; hif.ifid_rs = 5'd3; hif.ifid_rt = 5'd7; hif.ifid_uses_rt = 1'b1;
        @(negedge clk);
        check("lu_rt_ctl", 32'(ctl), 32'h34);
        next_cycle();
        hif.ifid_uses_rt = 1'b0;
        @(negedge clk);
        check("lu_rt_unused_ctl", 32'(ctl), 32'hF0);
        next_cycle();
        check("lu_rt_stall", 32'(hif.stall_cycles), 32'd2);
        idle();

        // branch redirect
        hif.ex_branch_taken = 1'b1;
        @(negedge clk);
        check("br_ctl", 32'(ctl), 32'hFC);
        next_cycle();
        idle();
        @(negedge clk);
        check("br_flush_cnt", 32'(hif.flush_events), 32'd1);
        check("br_after_ctl", 32'(ctl), 32'hF0);
        next_cycle();

        // redirect beats load-use
        hif.ex_branch_taken = 1'b1;
        hif.idex_memread = 1'b1; hif.idex_rt = 5'd9; hif.ifid_rs = 5'd9;
        @(negedge clk);
        check("br_lu_ctl", 32'(ctl), 32'hFC);
        next_cycle();
        idle();
        check("br_lu_flush_cnt", 32'(hif.flush_events), 32'd2);
        check("br_lu_stall", 32'(hif.stall_cycles), 32'd2);

        // three-cycle memory wait
        hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mw_ctl", 32'(ctl), 32'h01);
            check("mw_state", 32'(hif.ctrl_state), (i == 0) ? 32'd1 : 32'd2);
            next_cycle();
        end
        hif.mem_ready = 1'b1;
        @(negedge clk);
        check("mw_ready_ctl", 32'(ctl), 32'hF0);
        check("mw_ready_state", 32'(hif.ctrl_state), 32'd2);
        next_cycle();
        idle();
        check("mw_back_state", 32'(hif.ctrl_state), 32'd1);
        check("mw_stall", 32'(hif.stall_cycles), 32'd5);

        // jump held through a two-cycle wait
        hif.mem_req = 1'b1; hif.ex_jump = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mwj_ctl", 32'(ctl), 32'h01);
            next_cycle();
            check("mwj_flush_hold", 32'(hif.flush_events), 32'd2);
        end
        hif.mem_ready = 1'b1;
        @(negedge clk);
        check("mwj_ready_ctl", 32'(ctl), 32'hFC);
        next_cycle();
        idle();
        check("mwj_flush_cnt", 32'(hif.flush_events), 32'd3);
        check("mwj_stall", 32'(hif.stall_cycles), 32'd7);

        // timeout into ERROR
        hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0)  check("to_first_state", 32'(hif.ctrl_state), 32'd1);
            if (i == 63) check("to_last_state", 32'(hif.ctrl_state), 32'd2);
            if (i == 63) check("to_last_ctl", 32'(ctl), 32'h01);
            next_cycle();
        end
        @(negedge clk);
        check("err_state", 32'(hif.ctrl_state), 32'd3);
        check("err_flag", 32'(hif.mem_err), 32'd1);
        check("err_ctl", 32'(ctl), 32'h0F);
        check("err_stall", 32'(hif.stall_cycles), 32'd71);
        next_cycle();
        hif.mem_ready = 1'b1;
        next_cycle();
        check("err_sticky_state", 32'(hif.ctrl_state), 32'd3);
        check("sat_flush_cnt", 32'(hif_s.flush_events), 32'd3);
        check("sat_stall_cnt", 32'(hif_s.stall_cycles), 32'd0);

        // asynchronous reset mid-cycle restarts INIT
        rst_n = 1'b0;
        #2;
        check("rst2_state", 32'(hif.ctrl_state), 32'd0);
        check("rst2_stall", 32'(hif.stall_cycles), 32'd0);
        check("rst2_flush", 32'(hif.flush_events), 32'd0);
        check("rst2_err", 32'(hif.mem_err), 32'd0);
        check("rst2_sat_flush", 32'(hif_s.flush_events), 32'd0);
        next_cycle();
        idle();
        rst_n = 1'b1;
        init_sequence("reboot");
        repeat (4) next_cycle();
        check("sat2_flush_cnt", 32'(hif_s.flush_events), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
